opb_register_bank_ppc2simulink: RTL and testbench
=================================================

// Module: opb_register_bank_ppc2simulink
// PURPOSE
//  Parametrised OPB slave holding C_NUM_REGS 32-bit software registers in one address window.
//  Each register is one of three kinds, fixed per index by parameter:
//   - ppc2simulink level: PPC writes, fabric reads.
//   - ppc2simulink pulse: one-cycle trigger, e.g. snapshot start.
//   - simulink2ppc status: fabric drives, PPC reads.
//  Per-register write strobes let fabric logic react to a write without edge detection.
//  Everything runs on OPB_Clk; sits between the OPB bus and the DSP/snapshot control logic.
// PARAMETERS
//  C_BASEADDR     32'h010B2500  window base; must be aligned to window size
//  C_HIGHADDR     32'h010B25FF  window top, inclusive
//  C_OPB_AWIDTH   32            address width
//  C_OPB_DWIDTH   32            data width; only 32 supported
//  C_NUM_REGS     8             register count, 1..64
//  C_RD_MASK      64'h0         bit i=1: register i is simulink2ppc (read-only to PPC)
//  C_PULSE_MASK   64'h0         bit i=1: register i is pulse mode; ignored where C_RD_MASK bit i=1
//  C_RESET_VALUE  32'h0         reset value of every ppc2simulink level register
//  C_FAMILY       "virtex5"     target family; informational only
// PORTS
//  OPB_Clk         in   1        sole clock
//  OPB_Rst_n       in   1        asynchronous reset, active low
//  OPB_ABus        in   [0:31]   address; bit 0 is MSB
//  OPB_BE          in   [0:3]    byte enables; BE[0] selects DBus[0:7]
//  OPB_DBus        in   [0:31]   write data; bit 0 is MSB
//  OPB_RNW         in   1        1 = read, 0 = write
//  OPB_select      in   1        transfer request
//  OPB_seqAddr     in   1        accepted, ignored
//  Sl_DBus         out  [0:31]   read data; zero except during a read ack
//  Sl_xferAck      out  1        one-cycle transfer acknowledge
//  Sl_errAck       out  1        tied 0
//  Sl_retry        out  1        tied 0
//  Sl_toutSup      out  1        tied 0
//  user_data_out   out  N*32     register i at bits [32i+31:32i]; status slots read 0
//  user_data_in    in   N*32     status inputs, used only where C_RD_MASK=1
//  user_wr_strobe  out  N        bit i high one cycle when register i is written
// BEHAVIOUR
//  Bit mapping: DBus[k] <-> data[31-k]. BE[j] covers data[31-8j -: 8].
//  hit = OPB_select & (ABus in [BASE,HIGH]) & ~Sl_xferAck. Index idx = (ABus-BASE)>>2.
//  Two-state FSM, IDLE/ACK:
//   - IDLE -> ACK on hit; ACK -> IDLE unconditionally.
//   - Sl_xferAck=1 exactly in ACK, i.e. cycle T+1 for a hit sampled at edge T.
//   - Back-to-back transfers are therefore at least 2 cycles apart.
//  Write, idx<N, writable register:
//   - Each enabled byte is merged at edge T; disabled bytes are kept.
//   - user_data_out and user_wr_strobe[idx] reflect the write in cycle T+1, aligned with Sl_xferAck.
//   - BE=0000: acked, data unchanged, strobe still pulses.
//  Pulse register:
//   - Merged value (merged onto 0) appears for cycle T+1 only, then returns to 0.
//   - Reads return 0.
//  Read:
//   - Sl_DBus is driven in cycle T+1 only, otherwise all-zero (OR-bus rule).
//   - Level register: returns the stored value.
//   - Status register: returns user_data_in captured at edge T.
//  Out-of-range cases:
//   - idx>=N inside the window: acked; read returns 0; write ignored; no strobe.
//   - Write to a status register: acked, ignored, no strobe.
//   - Address outside the window: no response. The bus times out; this is not this block's job.
//  Reset, asynchronous, may occur mid-transfer:
//   - FSM to IDLE; Sl_xferAck=0, Sl_DBus=0, strobes=0.
//   - Level registers = C_RESET_VALUE; pulse registers = 0.
//   - A transfer in flight is dropped with no ack and no write.
//  Release: first hit is accepted at the first rising edge after OPB_Rst_n rises.
//  select dropped while in ACK: no effect; the transfer still completes.
// STRUCTURE
//  Shared include opb_reg_defs.vh:
//   - clog2 function.
//   - FSM state encodings.
//   - dbus2word / word2dbus bit-reversal functions.
//   - be_merge(old,new,be) function.
//  Sub-module opb_reg_slot, one generate instance per index:
//   - Parameters MODE (level/pulse/status) and RESET_VALUE.
//   - Inputs: wr_en, be, wdata, user_in.
//   - Outputs: rd_data, user_out, wr_strobe.
//  Top level holds: address decode, FSM, read mux, output zero-gating.
// TESTING
//  1. Reset, then write 0xDEADBEEF to BASE+0x00 (BE=1111).
//     -> Sl_xferAck in cycle T+1; user_data_out[31:0]=DEADBEEF and wr_strobe[0]=1 in T+1.
//     -> Readback returns DEADBEEF.
//  2. Write 0x11223344 to reg 1 (BE=1111), then 0xAABBCCDD with BE=0101.
//     -> reg 1 = 0x11BB33DD.
//  3. C_PULSE_MASK bit 2: write 0x1 to BASE+0x08.
//     -> user_data_out[95:64]=1 for exactly one cycle, then 0; read of reg 2 returns 0.
//  4. C_RD_MASK bit 3, user_data_in[127:96]=0xCAFE0001: read BASE+0x0C.
//     -> Sl_DBus=CAFE0001 in the ack cycle only.
//     -> A write to BASE+0x0C is acked; no strobe; the next read still returns the input value.
//  5. Edge addresses:
//     -> Read BASE+0x20 (idx 8, N=8) -> acked, data 0.
//     -> Access HIGH+4 -> no ack within 16 cycles.
//     -> select held high for 4 cycles -> acks in cycles 2 and 4 only.
//  6. Assert OPB_Rst_n low in the hit cycle of a write.
//     -> No ack, register keeps C_RESET_VALUE, all outputs zero during reset.

Source files
------------

// File: rtl/opb_register_bank_ppc2simulink_pkg.sv
// Shared types and helpers for the OPB software register bank.
package opb_register_bank_ppc2simulink_pkg;

    // Transfer FSM: a hit in StIdle is acknowledged from StAck one cycle later.
    typedef enum logic [0:0] {StIdle, StAck} state_e;

    // Per-slot register kind.
    typedef enum logic [1:0] {ModeLevel, ModePulse, ModeStatus} slot_mode_e;

    localparam int unsigned MaxRegs = 64;

    // OPB numbers bits MSB-first; convert to LSB-first words and back.
    function automatic logic [31:0] dbus2word(input logic [0:31] d);
        logic [31:0] w;
        for (int k = 0; k < 32; k++) begin
            w[31-k] = d[k];
        end
        return w;
    endfunction

    function automatic logic [0:31] word2dbus(input logic [31:0] w);
        logic [0:31] d;
        for (int k = 0; k < 32; k++) begin
            d[k] = w[31-k];
        end
        return d;
    endfunction

    // be[j] (LSB-first) selects byte w[8j+7:8j] from new_w, else keeps old_w.
    function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) begin
            r[8*j +: 8] = be[j] ? new_w[8*j +: 8] : old_w[8*j +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus signals, MSB-first numbering as on the bus.
interface opb_register_bank_ppc2simulink_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_bank_ppc2simulink_slot.sv
// One software register: level (PPC->fabric), pulse (one-cycle trigger) or status (fabric->PPC).
module opb_reg_slot
    import opb_register_bank_ppc2simulink_pkg::*;
#(
    parameter slot_mode_e  MODE        = ModeLevel,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] user_in_i,
    output logic [31:0] rd_data_o,
    output logic [31:0] user_out_o,
    output logic        wr_strobe_o
);
    localparam logic [31:0] ResetVal = (MODE == ModeLevel) ? RESET_VALUE : 32'h0;

    logic [31:0] value_q, value_d;
    logic        strobe_q;
    logic        unused_inputs;

    // Next value: level merges onto itself, pulse merges onto zero and self-clears.
    always_comb begin
        value_d = value_q;
        if (MODE == ModeLevel) begin
            if (wr_en_i) value_d = be_merge(value_q, wdata_i, be_i);
        end else if (MODE == ModePulse) begin
            value_d = wr_en_i ? be_merge(32'h0, wdata_i, be_i) : 32'h0;
        end else begin
            value_d = 32'h0;
        end
    end

    // Register state and the write strobe, both visible in the cycle after the write edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q  <= ResetVal;
            strobe_q <= 1'b0;
        end else begin
            value_q  <= value_d;
            strobe_q <= wr_en_i && (MODE != ModeStatus);
        end
    end

    assign user_out_o  = (MODE == ModeStatus) ? 32'h0 : value_q;
    assign rd_data_o   = (MODE == ModeLevel)  ? value_q :
                         (MODE == ModeStatus) ? user_in_i : 32'h0;
    assign wr_strobe_o = strobe_q;

    assign unused_inputs = ^{user_in_i, be_i, wdata_i};
endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS 32-bit software registers: decode, FSM, read mux, output gating.
module opb_register_bank_ppc2simulink
    import opb_register_bank_ppc2simulink_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'h010B2500,
    parameter logic [31:0] C_HIGHADDR    = 32'h010B25FF,
    parameter int unsigned C_OPB_AWIDTH  = 32,
    parameter int unsigned C_OPB_DWIDTH  = 32,
    parameter int unsigned C_NUM_REGS    = 8,
    parameter logic [63:0] C_RD_MASK     = 64'h0,
    parameter logic [63:0] C_PULSE_MASK  = 64'h0,
    parameter logic [31:0] C_RESET_VALUE = 32'h0,
    parameter string       C_FAMILY      = "virtex5"
) (
    input  logic                       OPB_Clk,
    input  logic                       OPB_Rst_n,
    opb_register_bank_ppc2simulink_if.slave opb,
    output logic [C_NUM_REGS*32-1:0]   user_data_out,
    input  logic [C_NUM_REGS*32-1:0]   user_data_in,
    output logic [C_NUM_REGS-1:0]      user_wr_strobe
);
    state_e                       state_q, state_d;
    logic [31:0]                  addr, wdata, offset, rd_mux, rd_q;
    logic [29:0]                  idx;
    logic [3:0]                   be;
    logic                         in_win, ack, hit;
    logic [C_NUM_REGS-1:0]        wr_en;
    logic [C_NUM_REGS-1:0][31:0]  slot_rd;
    logic                         unused_bus;

    assign addr   = dbus2word(opb.OPB_ABus);
    assign wdata  = dbus2word(opb.OPB_DBus);
    assign be     = {opb.OPB_BE[0], opb.OPB_BE[1], opb.OPB_BE[2], opb.OPB_BE[3]};
    assign in_win = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign offset = addr - C_BASEADDR;
    assign idx    = offset[31:2];
    assign ack    = (state_q == StAck);
    // Masking with ack stops a held select from re-hitting in the ack cycle.
    assign hit    = opb.OPB_select && in_win && !ack;

    // Per-index write enables and read mux; indices >= C_NUM_REGS match nothing.
    always_comb begin
        wr_en  = '0;
        rd_mux = 32'h0;
        for (int i = 0; i < int'(C_NUM_REGS); i++) begin
            wr_en[i] = hit && !opb.OPB_RNW && (idx == 30'(i));
            if (idx == 30'(i)) rd_mux = slot_rd[i];
        end
    end

    for (genvar i = 0; i < int'(C_NUM_REGS); i++) begin : g_slot
        localparam slot_mode_e Mode = C_RD_MASK[i]    ? ModeStatus :
                                      C_PULSE_MASK[i] ? ModePulse  : ModeLevel;
        opb_reg_slot #(
            .MODE        (Mode),
            .RESET_VALUE (C_RESET_VALUE)
        ) u_slot (
            .clk_i       (OPB_Clk),
            .rst_ni      (OPB_Rst_n),
            .wr_en_i     (wr_en[i]),
            .be_i        (be),
            .wdata_i     (wdata),
            .user_in_i   (user_data_in[32*i +: 32]),
            .rd_data_o   (slot_rd[i]),
            .user_out_o  (user_data_out[32*i +: 32]),
            .wr_strobe_o (user_wr_strobe[i])
        );
    end

    // Two-state transfer FSM: every hit gets exactly one ack cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (hit) state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state and read data captured at the hit edge.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q <= StIdle;
            rd_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            rd_q    <= (hit && opb.OPB_RNW) ? rd_mux : 32'h0;
        end
    end

    // OR-bus: read data only during the ack cycle.
    assign opb.Sl_DBus    = ack ? word2dbus(rd_q) : '0;
    assign opb.Sl_xferAck = ack;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    assign unused_bus = ^{opb.OPB_seqAddr, offset[1:0]};
endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed self-checking bench for the OPB register bank (reg 2 pulse, reg 3 status).
module tb_opb_register_bank_ppc2simulink;
    localparam logic [31:0] Base = 32'h010B2500;
    localparam logic [31:0] High = 32'h010B25FF;

    bit           clk = 1'b0;
    logic         rst_n;
    logic [255:0] udo, udi;
    logic [7:0]   ustb;
    int           n_pass = 0;
    int           n_total = 0;

    logic         a_ack;
    logic [31:0]  a_rd;
    logic [7:0]   a_stb;
    logic [255:0] a_udo;

    opb_register_bank_ppc2simulink_if bus ();

    opb_register_bank_ppc2simulink #(
        .C_NUM_REGS   (8),
        .C_RD_MASK    (64'h8),
        .C_PULSE_MASK (64'h4)
    ) dut (
        .OPB_Clk        (clk),
        .OPB_Rst_n      (rst_n),
        .opb            (bus.slave),
        .user_data_out  (udo),
        .user_data_in   (udi),
        .user_wr_strobe (ustb)
    );

    always #5 clk = ~clk;

    task automatic bus_idle();
        bus.OPB_select  = 1'b0;
        bus.OPB_ABus    = '0;
        bus.OPB_BE      = '0;
        bus.OPB_DBus    = '0;
        bus.OPB_RNW     = 1'b0;
        bus.OPB_seqAddr = 1'b0;
    endtask

    task automatic bus_drive(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata);
        bus.OPB_select = 1'b1;
        bus.OPB_RNW    = rnw;
        bus.OPB_ABus   = addr;
        bus.OPB_BE     = be;
        bus.OPB_DBus   = wdata;
    endtask

    // Single transfer; samples outputs #1 after the hit edge, returns at the next negedge.
    task automatic access(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
        @(negedge clk);
        bus_drive(rnw, addr, be, wdata);
        @(posedge clk);
        #1;
        a_ack = bus.Sl_xferAck;
        a_rd  = bus.Sl_DBus;
        a_stb = ustb;
        a_udo = udo;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        udi   = '0;
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (bus.Sl_xferAck !== 1'b0) $display("FAIL rst_ack got %b want 0", bus.Sl_xferAck); else n_pass++;
        n_total++; if (bus.Sl_DBus !== 32'h0) $display("FAIL rst_dbus got %h want 0", bus.Sl_DBus); else n_pass++;
        n_total++; if (ustb !== 8'h0) $display("FAIL rst_strobe got %h want 0", ustb); else n_pass++;
        n_total++; if (udo !== 256'h0) $display("FAIL rst_udo got %h want 0", udo); else n_pass++;
        // First hit accepted at the first rising edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        bus_drive(1'b1, Base, 4'hF, 32'h0);
        @(posedge clk);
        #1;
        n_total++; if (bus.Sl_xferAck !== 1'b1) $display("FAIL release_ack got %b want 1", bus.Sl_xferAck); else n_pass++;
        n_total++; if (bus.Sl_DBus !== 32'h0) $display("FAIL release_rd got %h want 0", bus.Sl_DBus); else n_pass++;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic test_write_level();
        access(1'b0, Base, 4'hF, 32'hDEADBEEF);
        n_total++; if (a_ack !== 1'b1) $display("FAIL wr0_ack got %b want 1", a_ack); else n_pass++;
        n_total++; if (a_udo[31:0] !== 32'hDEADBEEF) $display("FAIL wr0_udo got %h want deadbeef", a_udo[31:0]); else n_pass++;
        n_total++; if (a_stb !== 8'h01) $display("FAIL wr0_strobe got %h want 01", a_stb); else n_pass++;
        n_total++; if (a_rd !== 32'h0) $display("FAIL wr0_dbus got %h want 0", a_rd); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (bus.Sl_xferAck !== 1'b0) $display("FAIL wr0_ack_after got %b want 0", bus.Sl_xferAck); else n_pass++;
        n_total++; if (ustb !== 8'h00) $display("FAIL wr0_strobe_after got %h want 00", ustb); else n_pass++;
        access(1'b1, Base, 4'hF, 32'h0);
        n_total++; if (a_rd !== 32'hDEADBEEF) $display("FAIL rd0 got %h want deadbeef", a_rd); else n_pass++;
        // BE=0000: acked, strobe pulses, data unchanged.
        access(1'b0, Base, 4'h0, 32'h12345678);
        n_total++; if (a_ack !== 1'b1) $display("FAIL be0_ack got %b want 1", a_ack); else n_pass++;
        n_total++; if (a_stb !== 8'h01) $display("FAIL be0_strobe got %h want 01", a_stb); else n_pass++;
        n_total++; if (a_udo[31:0] !== 32'hDEADBEEF) $display("FAIL be0_udo got %h want deadbeef", a_udo[31:0]); else n_pass++;
    endtask

    task automatic test_byte_enable();
        access(1'b0, Base + 32'h4, 4'hF, 32'h11223344);
        n_total++; if (a_stb !== 8'h02) $display("FAIL wr1_strobe got %h want 02", a_stb); else n_pass++;
        access(1'b0, Base + 32'h4, 4'b0101, 32'hAABBCCDD);
        n_total++; if (a_udo[63:32] !== 32'h11BB33DD) $display("FAIL wr1_merge got %h want 11bb33dd", a_udo[63:32]); else n_pass++;
        access(1'b1, Base + 32'h4, 4'hF, 32'h0);
        n_total++; if (a_rd !== 32'h11BB33DD) $display("FAIL rd1 got %h want 11bb33dd", a_rd); else n_pass++;
    endtask

    task automatic test_pulse();
        access(1'b0, Base + 32'h8, 4'hF, 32'h1);
        n_total++; if (a_udo[95:64] !== 32'h1) $display("FAIL pulse_hi got %h want 1", a_udo[95:64]); else n_pass++;
        n_total++; if (a_stb !== 8'h04) $display("FAIL pulse_strobe got %h want 04", a_stb); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (udo[95:64] !== 32'h0) $display("FAIL pulse_lo got %h want 0", udo[95:64]); else n_pass++;
        access(1'b1, Base + 32'h8, 4'hF, 32'h0);
        n_total++; if (a_ack !== 1'b1) $display("FAIL pulse_rd_ack got %b want 1", a_ack); else n_pass++;
        n_total++; if (a_rd !== 32'h0) $display("FAIL pulse_rd got %h want 0", a_rd); else n_pass++;
    endtask

    task automatic test_status();
        udi[127:96] = 32'hCAFE0001;
        access(1'b1, Base + 32'hC, 4'hF, 32'h0);
        n_total++; if (a_rd !== 32'hCAFE0001) $display("FAIL stat_rd got %h want cafe0001", a_rd); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (bus.Sl_DBus !== 32'h0) $display("FAIL stat_dbus_after got %h want 0", bus.Sl_DBus); else n_pass++;
        access(1'b0, Base + 32'hC, 4'hF, 32'h55555555);
        n_total++; if (a_ack !== 1'b1) $display("FAIL stat_wr_ack got %b want 1", a_ack); else n_pass++;
        n_total++; if (a_stb !== 8'h00) $display("FAIL stat_wr_strobe got %h want 00", a_stb); else n_pass++;
        n_total++; if (a_udo[127:96] !== 32'h0) $display("FAIL stat_udo got %h want 0", a_udo[127:96]); else n_pass++;
        access(1'b1, Base + 32'hC, 4'hF, 32'h0);
        n_total++; if (a_rd !== 32'hCAFE0001) $display("FAIL stat_rd2 got %h want cafe0001", a_rd); else n_pass++;
    endtask

    task automatic test_edges();
        int acks;
        logic [3:0] pat;
        access(1'b1, Base + 32'h20, 4'hF, 32'h0);
        n_total++; if (a_ack !== 1'b1) $display("FAIL idx8_ack got %b want 1", a_ack); else n_pass++;
        n_total++; if (a_rd !== 32'h0) $display("FAIL idx8_rd got %h want 0", a_rd); else n_pass++;
        access(1'b0, Base + 32'h20, 4'hF, 32'hFFFFFFFF);
        n_total++; if (a_stb !== 8'h00) $display("FAIL idx8_strobe got %h want 00", a_stb); else n_pass++;
        // Outside the window: no ack within 16 cycles.
        acks = 0;
        @(negedge clk);
        bus_drive(1'b1, High + 32'h4, 4'hF, 32'h0);
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            if (bus.Sl_xferAck === 1'b1) acks++;
        end
        @(negedge clk);
        bus_idle();
        n_total++; if (acks !== 0) $display("FAIL outside_acks got %0d want 0", acks); else n_pass++;
        // Held select: ack every other cycle.
        @(negedge clk);
        bus_drive(1'b1, Base, 4'hF, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            pat[c] = bus.Sl_xferAck;
        end
        @(negedge clk);
        bus_idle();
        n_total++; if (pat !== 4'b0101) $display("FAIL held_sel_acks got %b want 0101", pat); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus_drive(1'b0, Base + 32'h4, 4'hF, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        n_total++; if (udo !== 256'h0) $display("FAIL mid_rst_async got %h want 0", udo); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (bus.Sl_xferAck !== 1'b0) $display("FAIL mid_rst_ack got %b want 0", bus.Sl_xferAck); else n_pass++;
        n_total++; if (ustb !== 8'h0) $display("FAIL mid_rst_strobe got %h want 0", ustb); else n_pass++;
        n_total++; if (bus.Sl_DBus !== 32'h0) $display("FAIL mid_rst_dbus got %h want 0", bus.Sl_DBus); else n_pass++;
        @(negedge clk);
        bus_idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++; if (udo[63:32] !== 32'h0) $display("FAIL mid_rst_reg1 got %h want 0", udo[63:32]); else n_pass++;
        access(1'b1, Base + 32'h4, 4'hF, 32'h0);
        n_total++; if (a_rd !== 32'h0) $display("FAIL mid_rst_rd1 got %h want 0", a_rd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_level();
        test_byte_enable();
        test_pulse();
        test_status();
        test_edges();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
